// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter feeding a single 8N1 UART transmitter.
// Latency: grant/tx/busy registered, one cycle after the accepting IDLE edge.
// Backpressure: requesters hold req until granted; req is ignored while busy.
module uart_tx_arbiter #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  grant,
    output logic        tx,
    output logic        busy
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       last_q, last_d;
    logic             tx_d, busy_d;
    logic [3:0]       grant_d;

    logic [1:0]       pick;
    logic             found;
    logic             bit_end;

    // Search starts just past the last winner, so it ends up lowest priority.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[last_q + 2'(k)]) begin
                found = 1'b1;
                pick  = last_q + 2'(k);
            end
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        tx_d    = tx;
        busy_d  = busy;
        grant_d = 4'b0000;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (found) begin
                    grant_d = 4'b0001 << pick;
                    last_d  = pick;
                    shift_d = data_in[{pick, 3'b000} +: 8];
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift register keeps the next bit at [1] for the registered tx.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            last_q  <= 2'd3;
            tx      <= 1'b1;
            busy    <= 1'b0;
            grant   <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            tx      <= tx_d;
            busy    <= busy_d;
            grant   <= grant_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a grant/byte scoreboard queue.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic        tx;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_gcyc = -1;
    logic [11:0] exp_q[$];

    uart_tx_arbiter #(.CLK_FREQ(40), .BAUD_RATE(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data_in (data_in),
        .grant   (grant),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for the next grant, then checks one full frame against the head of the queue.
    task automatic frame(input string tag, input logic [3:0] clr_mask, input bit chk_gap,
                         input int e1c, input logic [3:0] e1r,
                         input int e2c, input logic [3:0] e2r);
        logic [11:0] e;
        logic [39:0] exp_line, obs_line, obs_busy;
        logic [3:0]  gacc;
        logic [31:0] saved;
        int          w;
        int          j;
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q.pop_front();
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (grant === 4'b0000 && w < 400);
        check({tag, " grant"}, 64'(grant), 64'(e[11:8]));
        if (grant === 4'b0000) return;
        if (chk_gap) check({tag, " gap"}, 64'(cyc - last_gcyc), 64'd41);
        last_gcyc = cyc;
        gacc  = 4'b0000;
        saved = data_in;
        for (int i = 0; i < 40; i++) begin
            j = i / 4;
            exp_line[i] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : e[j-1];
            obs_line[i] = tx;
            obs_busy[i] = busy;
            if (i > 0) gacc = gacc | grant;
            if (i == 0) req = req & ~clr_mask;
            if (i == e1c) req = e1r;
            if (i == e2c) req = e2r;
            if (i == 5) data_in = $urandom();
            if (i == 35) data_in = saved;
            @(negedge clk);
        end
        check({tag, " line"}, 64'(obs_line), 64'(exp_line));
        check({tag, " busy"}, 64'(obs_busy), {24'd0, 40'hFF_FFFF_FFFF});
        check({tag, " no grant mid-frame"}, 64'(gacc), 64'd0);
        check({tag, " idle tx/busy/grant"}, {58'd0, tx, busy, grant}, {58'd0, 1'b1, 1'b0, 4'b0000});
    endtask

    task automatic do_reset(input logic [3:0] req_during);
        @(negedge clk);
        reset = 1'b1;
        req   = req_during;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset state", {58'd0, tx, busy, grant}, {58'd0, 1'b1, 1'b0, 4'b0000});
        end
        reset = 1'b0;
        req   = 4'b0000;
        last_gcyc = -1;
    endtask

    initial begin
        logic [3:0] gacc;
        logic       txand, busyor;
        int         w;
        reset   = 1'b1;
        req     = 4'b0000;
        data_in = 32'h0;

        // Reset wins over concurrent requests
        do_reset(4'b1111);

        // Single request
        @(negedge clk);
        data_in = 32'h000000A5;
        req     = 4'b0001;
        exp_q.push_back({4'b0001, 8'hA5});
        frame("single", 4'b0001, 1'b0, -1, 4'b0, -1, 4'b0);

        // Contention, all four held
        do_reset(4'b0000);
        data_in = 32'h44332211;
        req     = 4'b1111;
        exp_q.push_back({4'b0001, 8'h11});
        exp_q.push_back({4'b0010, 8'h22});
        exp_q.push_back({4'b0100, 8'h33});
        exp_q.push_back({4'b1000, 8'h44});
        exp_q.push_back({4'b0001, 8'h11});
        frame("cont1", 4'b0000, 1'b0, -1, 4'b0, -1, 4'b0);
        frame("cont2", 4'b0000, 1'b1, -1, 4'b0, -1, 4'b0);
        frame("cont3", 4'b0000, 1'b1, -1, 4'b0, -1, 4'b0);
        frame("cont4", 4'b0000, 1'b1, -1, 4'b0, -1, 4'b0);
        frame("cont5", 4'b1111, 1'b1, -1, 4'b0, -1, 4'b0);

        // Fairness between requesters 0 and 2
        do_reset(4'b0000);
        data_in = 32'hC35A963C;
        req     = 4'b0101;
        exp_q.push_back({4'b0001, 8'h3C});
        exp_q.push_back({4'b0100, 8'h5A});
        exp_q.push_back({4'b0001, 8'h3C});
        frame("fair1", 4'b0000, 1'b0, -1, 4'b0, -1, 4'b0);
        frame("fair2", 4'b0000, 1'b1, -1, 4'b0, -1, 4'b0);
        frame("fair3", 4'b0101, 1'b1, -1, 4'b0, -1, 4'b0);

        // Late request raised mid-frame
        @(negedge clk);
        data_in = 32'h00E70081;
        req     = 4'b0001;
        exp_q.push_back({4'b0001, 8'h81});
        exp_q.push_back({4'b0100, 8'hE7});
        frame("late0", 4'b0001, 1'b0, 20, 4'b0100, -1, 4'b0);
        frame("late2", 4'b0100, 1'b1, -1, 4'b0, -1, 4'b0);

        // Mid-frame reset during DATA bit 3
        do_reset(4'b0000);
        data_in = 32'h00007E00;
        req     = 4'b0001;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (grant === 4'b0000 && w < 400);
        check("rst grant", 64'(grant), 64'd1);
        req = 4'b0000;
        repeat (17) @(negedge clk);
        check("rst pre tx/busy", {62'd0, tx, busy}, {62'd0, 1'b0, 1'b1});
        reset = 1'b1;
        @(negedge clk);
        check("rst abort", {58'd0, tx, busy, grant}, {58'd0, 1'b1, 1'b0, 4'b0000});
        reset = 1'b0;
        last_gcyc = -1;
        req = 4'b0010;
        exp_q.push_back({4'b0010, 8'h7E});
        frame("post-rst1", 4'b0010, 1'b0, -1, 4'b0, -1, 4'b0);
        req = 4'b0001;
        exp_q.push_back({4'b0001, 8'h00});
        frame("post-rst0", 4'b0001, 1'b0, -1, 4'b0, -1, 4'b0);

        // Withdrawn request pulsed only while busy
        @(negedge clk);
        data_in = 32'h0000005C;
        req     = 4'b0001;
        exp_q.push_back({4'b0001, 8'h5C});
        frame("withdraw", 4'b0001, 1'b0, 10, 4'b1000, 30, 4'b0000);
        gacc   = 4'b0000;
        txand  = 1'b1;
        busyor = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            gacc   = gacc | grant;
            txand  = txand & tx;
            busyor = busyor | busy;
        end
        check("withdraw quiet", {58'd0, txand, busyor, gacc}, {58'd0, 1'b1, 1'b0, 4'b0000});
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, serial bit rate; BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer division), legal range >= 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req, input, 4, per-requester transmit request; bit i belongs to requester i.
REQ-006 The block SHALL have port data_in, input, 32, packed request bytes; byte i = data_in[8i+7:8i].
REQ-007 The block SHALL have port grant, output, 4, one-hot one-cycle pulse marking the requester whose byte was accepted.
REQ-008 The block SHALL have port tx, output, 1, serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1, high while a frame is on the line.

Function
REQ-010 The block SHALL use FSM states IDLE, START, DATA, STOP; all outputs registered.
REQ-011 The block SHALL keep an internal bit-time counter running 0..BIT_CYCLES-1, cleared on every state entry; each line bit lasts exactly BIT_CYCLES cycles.
REQ-012 In IDLE with req != 0, at the next edge the block SHALL select one requester round-robin, latch its byte, pulse grant for one cycle, drive tx=0, busy=1, enter START.
REQ-013 Round-robin SHALL search from (last_granted+1) mod 4 upward with wrap, so the last granted requester has lowest priority; last_granted updates only on a grant.
REQ-014 START SHALL hold tx=0 for BIT_CYCLES cycles, then enter DATA.
REQ-015 DATA SHALL shift out the latched byte LSB first, 8 bits of BIT_CYCLES cycles each, with a 3-bit bit index counting 0..7, then enter STOP.
REQ-016 STOP SHALL hold tx=1 for BIT_CYCLES cycles, then enter IDLE with busy=0.
REQ-017 A frame SHALL occupy exactly 10*BIT_CYCLES cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle (tx=1, busy=0).
REQ-018 req SHALL be sampled only in IDLE; requests during START/DATA/STOP SHALL be ignored and not queued; requesters hold req until granted.
REQ-019 A req deasserted before its grant SHALL produce no grant and no frame.
REQ-020 data_in changes after the grant edge SHALL NOT affect the frame in progress.
REQ-021 grant SHALL be all-zero in every cycle except the single cycle following an acceptance edge.

Reset
REQ-022 reset SHALL force state=IDLE, tx=1, busy=0, grant=0, bit index=0, bit-time counter=0, last_granted=3 (so requester 0 has first priority).
REQ-023 reset asserted mid-frame SHALL abort the frame; tx=1 and busy=0 from the cycle after the reset edge, and no grant issues while reset is high.
REQ-024 reset SHALL take priority over every other event in the same cycle.

Verification (CLK_FREQ=40, BAUD_RATE=10, BIT_CYCLES=4)
REQ-025 Single request: req=0001, byte0=0xA5 -> grant=0001 one cycle; tx = 0 x4, then 1,0,1,0,0,1,0,1 x4 each, then 1 x4; busy high 40 cycles.
REQ-026 Contention: req=1111 held, bytes 0x11/0x22/0x33/0x44 -> grants in order 0001,0010,0100,1000,0001; grants 41 cycles apart.
REQ-027 Fairness: req=0101 held after reset -> grants alternate 0001,0100,0001.
REQ-028 Late request: req[2] raised mid-frame of requester 0 -> no grant until IDLE cycle, then grant=0100; no frame corruption.
REQ-029 Mid-frame reset: reset in DATA bit 3 for one cycle -> tx=1, busy=0 next cycle; subsequent req=0010 granted before requester 0.
REQ-030 Withdrawn request: req pulse high only during a busy frame -> no grant, tx stays 1 after frame.
